// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C write-only codec control target:
//   - i2c_state_t     : target FSM state encoding
//   - CODEC_ADDR      : 7-bit address of the modelled audio codec
//   - CODEC_WIRE_BYTE : first byte on the wire for a write to the codec
//   - REG_RESET_ADDR  : register address that clears the whole bank
//   - wire_byte()     : 7-bit address -> write address byte (R/W = 0)
// -----------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_ACK_A  = 3'd2,
      ST_SUB    = 3'd3,
      ST_ACK_S  = 3'd4,
      ST_DATA   = 3'd5,
      ST_ACK_D  = 3'd6,
      ST_IGNORE = 3'd7
   } i2c_state_t;

   localparam logic [6:0] CODEC_ADDR     = 7'h1A;
   localparam logic [6:0] REG_RESET_ADDR = 7'h0F;

   function automatic logic [7:0] wire_byte(input logic [6:0] addr);
      return {addr, 1'b0};
   endfunction

   localparam logic [7:0] CODEC_WIRE_BYTE = wire_byte(CODEC_ADDR);

endpackage

// File: rtl/i2c_line_filter.sv
// -----------------------------------------------------------------------------
// i2c_line_filter
// Conditions one oversampled I2C line: 2-FF synchroniser followed by a
// FILT_LEN-sample persistence filter. The filtered level only moves after the
// synchronised input has differed from it for FILT_LEN consecutive clocks.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   line         : raw pin value
//   level        : filtered level (resets to 1, the idle bus level)
//   rise, fall   : one-clk pulses, asserted in the first clk the new level shows
// -----------------------------------------------------------------------------
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(FILT_LEN + 1);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] cnt;
   logic          accept;

   // The FILT_LEN-th consecutive differing sample flips the level.
   assign accept = (sync_2 != level) && (cnt == CW'(FILT_LEN - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         level  <= 1'b1;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_1 <= line;
         sync_2 <= sync_1;
         rise   <= accept && sync_2;
         fall   <= accept && !sync_2;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (accept) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_codec_target.sv
// -----------------------------------------------------------------------------
// i2c_codec_target
// Write-only I2C target modelling an audio codec control port. Accepts frames
// {addr+W, {reg[6:0],d[8]}, d[7:0]} and stores 9-bit words in a register bank.
// SCL/SDA are oversampled on clk; they are never used as clocks.
// Ports:
//   clk, reset_n : 50 MHz system clock, async active-low reset
//   i2c_sclk     : I2C clock from the initiator
//   i2c_sdat     : I2C data, open-drain (driven 0 or z only)
//   wr_en        : one-clk strobe, a complete write frame was accepted
//   wr_addr      : register address of the last accepted write
//   wr_data      : data of the last accepted write
//   rd_addr      : combinational readback address
//   rd_data      : bank[rd_addr], 0 when rd_addr >= NUM_REGS
//   busy         : high from START until STOP
//   frame_err    : one-clk strobe, matched frame aborted before commit
// Strobe semantics: wr_en and frame_err are single-cycle events with no
// back-pressure; wr_addr/wr_data are valid in the wr_en cycle and hold after.
// -----------------------------------------------------------------------------
module i2c_codec_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = CODEC_ADDR,
   parameter int         FILT_LEN   = 3,
   parameter int         NUM_REGS   = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i2c_sclk,
   inout  wire        i2c_sdat,
   output logic       wr_en,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       busy,
   output logic       frame_err
);

   localparam logic [7:0] ADDR_BYTE = wire_byte(SLAVE_ADDR);

   logic       scl;
   logic       scl_rise;
   logic       scl_fall;
   logic       sda;
   logic       sda_rise;
   logic       sda_fall;
   logic       start_det;
   logic       stop_det;
   logic       byte_done;
   logic       commit;
   logic       abort;
   logic       sda_oe;
   logic [3:0] bit_cnt;
   logic [7:0] shift;
   logic [7:0] sub_q;
   logic [8:0] bank [NUM_REGS];

   i2c_state_t state;
   i2c_state_t next_state;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .line    (i2c_sclk),
      .level   (scl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .line    (i2c_sdat),
      .level   (sda),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   // SCL must be high and not moving this clk; an SCL edge coinciding with an
   // SDA edge wins and the SDA edge is treated as a data transition.
   assign start_det = sda_fall && scl && !scl_rise;
   assign stop_det  = sda_rise && scl && !scl_rise;
   assign byte_done = scl_fall && (bit_cnt == 4'd8);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      next_state = state;
      if (start_det) begin
         next_state = ST_ADDR;
      end else if (stop_det) begin
         next_state = ST_IDLE;
      end else if (scl_fall) begin
         unique case (state)
            ST_ADDR:   if (byte_done) next_state = (shift == ADDR_BYTE) ? ST_ACK_A : ST_IGNORE;
            ST_ACK_A:  next_state = ST_SUB;
            ST_SUB:    if (byte_done) next_state = ST_ACK_S;
            ST_ACK_S:  next_state = ST_DATA;
            ST_DATA:   if (byte_done) next_state = ST_ACK_D;
            ST_ACK_D:  next_state = ST_IGNORE;
            default:   next_state = state;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // ACK states are entered and left on SCL fall, so deriving the SDA drive
   // from the state keeps SDA changes aligned to SCL fall (and reset releases
   // the line asynchronously).
   always_comb begin
      sda_oe = (state == ST_ACK_A) || (state == ST_ACK_S) || (state == ST_ACK_D);
      busy   = (state != ST_IDLE);
      commit = (state == ST_DATA) && byte_done;
      abort  = (start_det || stop_det) &&
               ((state == ST_ACK_A) || (state == ST_SUB) ||
                (state == ST_ACK_S) || (state == ST_DATA));
   end

   assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

   // ---------------- shifter, bit counter, strobes ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt   <= '0;
         shift     <= '0;
         sub_q     <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_en     <= commit;
         frame_err <= abort;
         if (start_det) begin
            bit_cnt <= '0;
         end else if (scl_rise && (bit_cnt < 4'd8) &&
                      ((state == ST_ADDR) || (state == ST_SUB) || (state == ST_DATA))) begin
            shift   <= {shift[6:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
         end else if (scl_fall && ((state == ST_ACK_A) || (state == ST_ACK_S))) begin
            bit_cnt <= '0;
         end
         if ((state == ST_SUB) && byte_done) sub_q <= shift;
         if (commit) begin
            wr_addr <= sub_q[7:1];
            wr_data <= {sub_q[0], shift};
         end
      end
   end

   // ---------------- register bank ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (sub_q[7:1] == REG_RESET_ADDR)  bank[i] <= '0;
            else if (sub_q[7:1] == 7'(i))      bank[i] <= {sub_q[0], shift};
         end
      end
   end

   assign rd_data = ({28'd0, rd_addr} < 32'(NUM_REGS)) ? bank[rd_addr] : 9'h000;

endmodule
